// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with tear-free frame-boundary capture.
// Optional decimal points are compiled in when SEVEN_SEG_DP_EN is defined.
module seven_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
`ifdef SEVEN_SEG_DP_EN
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  dp_n,
`endif
  output logic                  busy,
  output logic                  frame_done,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [4*DIGITS-1:0] shown_q, shown_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                tick;
  logic                boundary;
  logic [3:0]          nib;
  logic                upper_zero;
  logic                lz_blank;

  function automatic logic [6:0] decode(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0011000;
      4'hA: g = hex ? 7'b0001000 : 7'b1111111;
      4'hB: g = hex ? 7'b0000011 : 7'b1111111;
      4'hC: g = hex ? 7'b1000110 : 7'b1111111;
      4'hD: g = hex ? 7'b0100001 : 7'b1111111;
      4'hE: g = hex ? 7'b0000110 : 7'b1111111;
      default: g = hex ? 7'b0001110 : 7'b1111111;
    endcase
    return g;
  endfunction

  // load is a one-cycle strobe with no backpressure: the last strobe before a
  // frame boundary wins, and busy is high while a captured value waits for it.
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    boundary     = tick && (idx_q == IDX_LAST);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    pend_d       = pend_q;
    shown_d      = shown_q;
    busy_d       = busy_q;
    if (boundary) begin
      busy_d = 1'b0;
      if (load) begin
        shown_d = value;
      end else if (busy_q) begin
        shown_d = pend_q;
      end
    end else if (load) begin
      pend_d = value;
      busy_d = 1'b1;
    end
    frame_done_d = boundary;

    // Digit under scan plus "this digit and all above it are zero" for blanking.
    nib        = 4'h0;
    an_d       = '1;
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if (j == int'(idx_q)) begin
        nib     = shown_q[4*j +: 4];
        an_d[j] = 1'b0;
      end
      if ((j >= int'(idx_q)) && (shown_q[4*j +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    lz_blank = blank_lz && (idx_q != '0) && upper_zero;
    seg_d    = lz_blank ? 7'b1111111 : decode(nib, hex_mode);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_q       <= '0;
      shown_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      shown_q      <= shown_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

`ifdef SEVEN_SEG_DP_EN
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0] shown_dp_q, shown_dp_d;
  logic              dp_n_q, dp_n_d;
  logic              dp_bit;

  always_comb begin
    dp_bit     = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (j == int'(idx_q)) begin
        dp_bit = shown_dp_q[j];
      end
    end
    pend_dp_d  = pend_dp_q;
    shown_dp_d = shown_dp_q;
    if (boundary) begin
      if (load) begin
        shown_dp_d = dp_in;
      end else if (busy_q) begin
        shown_dp_d = pend_dp_q;
      end
    end else if (load) begin
      pend_dp_d = dp_in;
    end
    dp_n_d = lz_blank | ~dp_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_dp_q  <= '0;
      shown_dp_q <= '0;
      dp_n_q     <= 1'b1;
    end else begin
      pend_dp_q  <= pend_dp_d;
      shown_dp_q <= shown_dp_d;
      dp_n_q     <= dp_n_d;
    end
  end

  assign dp_n = dp_n_q;
`endif

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan at DIGITS=4, REFRESH_DIV=4 (16-cycle frames).
// Decimal-point checks are included when SEVEN_SEG_DP_EN is defined.
module tb_seven_seg_scan;
  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam logic [3:0] AN_EXP [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic        frame_done;
  logic [6:0]  seg;
  logic [3:0]  an;
`ifdef SEVEN_SEG_DP_EN
  logic [3:0]  dp_in;
  logic        dp_n;
  logic        cap_dp [16];
`endif

  logic [6:0]  cap_seg  [16];
  logic [3:0]  cap_an   [16];
  logic        cap_fd   [16];
  logic        cap_busy [16];

  int pass_cnt  = 0;
  int total_cnt = 0;

  seven_seg_scan #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .load(load),
    .hex_mode(hex_mode),
    .blank_lz(blank_lz),
`ifdef SEVEN_SEG_DP_EN
    .dp_in(dp_in),
    .dp_n(dp_n),
`endif
    .busy(busy),
    .frame_done(frame_done),
    .seg(seg),
    .an(an)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one 16-edge frame, optionally strobing load before edge ld_a / ld_b
  // (edge 15 is the frame boundary), and records outputs after each edge.
  task automatic capture_frame(input int ld_a, input logic [15:0] val_a,
                               input int ld_b, input logic [15:0] val_b);
    for (int c = 0; c < 16; c++) begin
      if (c == ld_a) begin
        load  = 1'b1;
        value = val_a;
      end else if (c == ld_b) begin
        load  = 1'b1;
        value = val_b;
      end else begin
        load  = 1'b0;
      end
      step();
      cap_seg[c]  = seg;
      cap_an[c]   = an;
      cap_fd[c]   = frame_done;
      cap_busy[c] = busy;
`ifdef SEVEN_SEG_DP_EN
      cap_dp[c]   = dp_n;
`endif
    end
    load = 1'b0;
  endtask

  task automatic wait_boundary(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      if (frame_done === 1'b1) seen = 1'b1;
    end
    total_cnt++;
    if (!seen) $display("FAIL %s: frame_done not seen within 40 cycles", name);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = '0; hex_mode = 1'b0; blank_lz = 1'b0;
`ifdef SEVEN_SEG_DP_EN
    dp_in = '0;
`endif
    repeat (3) step();
    total_cnt++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h expected 7f", seg); else pass_cnt++;
    total_cnt++; if (an !== 4'hF) $display("FAIL reset_an: got %h expected f", an); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_fd: got %b expected 0", frame_done); else pass_cnt++;
`ifdef SEVEN_SEG_DP_EN
    total_cnt++; if (dp_n !== 1'b1) $display("FAIL reset_dp: got %b expected 1", dp_n); else pass_cnt++;
`endif
    reset = 1'b0;
    step();
    total_cnt++; if (an !== 4'hE) $display("FAIL release_an: got %h expected e", an); else pass_cnt++;
    total_cnt++; if (seg !== 7'h40) $display("FAIL release_seg: got %h expected 40", seg); else pass_cnt++;
  endtask

  task automatic test_scan();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    reset = 1'b1;
    step();
    reset = 1'b0; load = 1'b1; value = 16'h1234;
    step();
    load = 1'b0;
    total_cnt++; if (an !== 4'hE) $display("FAIL scan_first_an: got %h expected e", an); else pass_cnt++;
    total_cnt++; if (seg !== 7'h40) $display("FAIL scan_first_seg: got %h expected 40", seg); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL scan_busy_set: got %b expected 1", busy); else pass_cnt++;
    for (int k = 2; k <= 15; k++) begin
      step();
      total_cnt++;
      if (busy !== 1'b1) $display("FAIL scan_busy_hold k=%0d: got %b expected 1", k, busy); else pass_cnt++;
      total_cnt++;
      if (frame_done !== 1'b0) $display("FAIL scan_fd_low k=%0d: got %b expected 0", k, frame_done); else pass_cnt++;
    end
    step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL scan_busy_clear: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL scan_fd_pulse: got %b expected 1", frame_done); else pass_cnt++;
    repeat (2) begin
      capture_frame(-1, '0, -1, '0);
      for (int c = 0; c < 16; c++) begin
        total_cnt++;
        if (cap_seg[c] !== exp_seg[c/4]) $display("FAIL scan_seg c=%0d: got %h expected %h", c, cap_seg[c], exp_seg[c/4]); else pass_cnt++;
        total_cnt++;
        if (cap_an[c] !== AN_EXP[c/4]) $display("FAIL scan_an c=%0d: got %h expected %h", c, cap_an[c], AN_EXP[c/4]); else pass_cnt++;
        total_cnt++;
        if (cap_fd[c] !== (c == 15)) $display("FAIL scan_fd c=%0d: got %b expected %b", c, cap_fd[c], c == 15); else pass_cnt++;
      end
    end
  endtask

  task automatic test_mid_frame();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    capture_frame(3, 16'h1111, 9, 16'h2222);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== exp_seg[c/4]) $display("FAIL mid_unchanged c=%0d: got %h expected %h", c, cap_seg[c], exp_seg[c/4]); else pass_cnt++;
      total_cnt++;
      if (cap_busy[c] !== (c >= 3 && c <= 14)) $display("FAIL mid_busy c=%0d: got %b expected %b", c, cap_busy[c], c >= 3 && c <= 14); else pass_cnt++;
    end
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== 7'h24) $display("FAIL mid_last_wins c=%0d: got %h expected 24", c, cap_seg[c]); else pass_cnt++;
      total_cnt++;
      if (cap_an[c] !== AN_EXP[c/4]) $display("FAIL mid_an c=%0d: got %h expected %h", c, cap_an[c], AN_EXP[c/4]); else pass_cnt++;
    end
  endtask

  task automatic test_boundary_load();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h00, 7'h78, 7'h02, 7'h12};
    capture_frame(15, 16'h5678, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== 7'h24) $display("FAIL bnd_old_frame c=%0d: got %h expected 24", c, cap_seg[c]); else pass_cnt++;
      total_cnt++;
      if (cap_busy[c] !== 1'b0) $display("FAIL bnd_busy c=%0d: got %b expected 0", c, cap_busy[c]); else pass_cnt++;
    end
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== exp_seg[c/4]) $display("FAIL bnd_new_frame c=%0d: got %h expected %h", c, cap_seg[c], exp_seg[c/4]); else pass_cnt++;
    end
  endtask

  task automatic test_hex_mode();
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h0E, 7'h46, 7'h03, 7'h08};
    hex_mode = 1'b1;
    capture_frame(15, 16'hABCF, -1, '0);
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== exp_seg[c/4]) $display("FAIL hex_on c=%0d: got %h expected %h", c, cap_seg[c], exp_seg[c/4]); else pass_cnt++;
    end
    hex_mode = 1'b0;
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== 7'h7F) $display("FAIL hex_off c=%0d: got %h expected 7f", c, cap_seg[c]); else pass_cnt++;
      total_cnt++;
      if (cap_an[c] !== AN_EXP[c/4]) $display("FAIL hex_off_an c=%0d: got %h expected %h", c, cap_an[c], AN_EXP[c/4]); else pass_cnt++;
    end
  endtask

  task automatic test_blank_lz();
    logic [6:0] exp_on [4];
    logic [6:0] exp_off [4];
    logic [6:0] exp_zero [4];
    exp_on   = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    exp_off  = '{7'h40, 7'h12, 7'h40, 7'h40};
    exp_zero = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    blank_lz = 1'b1;
    capture_frame(15, 16'h0050, -1, '0);
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== exp_on[c/4]) $display("FAIL lz_on c=%0d: got %h expected %h", c, cap_seg[c], exp_on[c/4]); else pass_cnt++;
      total_cnt++;
      if (cap_an[c] !== AN_EXP[c/4]) $display("FAIL lz_an c=%0d: got %h expected %h", c, cap_an[c], AN_EXP[c/4]); else pass_cnt++;
    end
    blank_lz = 1'b0;
    capture_frame(15, 16'h0000, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== exp_off[c/4]) $display("FAIL lz_off c=%0d: got %h expected %h", c, cap_seg[c], exp_off[c/4]); else pass_cnt++;
    end
    blank_lz = 1'b1;
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== exp_zero[c/4]) $display("FAIL lz_zero c=%0d: got %h expected %h", c, cap_seg[c], exp_zero[c/4]); else pass_cnt++;
    end
    blank_lz = 1'b0;
  endtask

`ifdef SEVEN_SEG_DP_EN
  task automatic test_dp();
    dp_in = 4'b0100;
    capture_frame(15, 16'h1234, -1, '0);
    dp_in = 4'b0000;
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_dp[c] !== (c/4 != 2)) $display("FAIL dp c=%0d: got %b expected %b", c, cap_dp[c], c/4 != 2); else pass_cnt++;
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    repeat (5) step();
    load = 1'b1; value = 16'h9999;
    step();
    load = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("FAIL rst_mid_pend: got %b expected 1", busy); else pass_cnt++;
    repeat (2) step();
    reset = 1'b1;
    step();
    total_cnt++; if (seg !== 7'h7F) $display("FAIL rst_mid_seg: got %h expected 7f", seg); else pass_cnt++;
    total_cnt++; if (an !== 4'hF) $display("FAIL rst_mid_an: got %h expected f", an); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL rst_mid_fd: got %b expected 0", frame_done); else pass_cnt++;
    reset = 1'b0;
    wait_boundary("rst_mid_boundary");
    capture_frame(-1, '0, -1, '0);
    for (int c = 0; c < 16; c++) begin
      total_cnt++;
      if (cap_seg[c] !== 7'h40) $display("FAIL rst_mid_discard c=%0d: got %h expected 40", c, cap_seg[c]); else pass_cnt++;
      total_cnt++;
      if (cap_busy[c] !== 1'b0) $display("FAIL rst_mid_busy_after c=%0d: got %b expected 0", c, cap_busy[c]); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mid_frame();
    test_boundary_load();
    test_hex_mode();
    test_blank_lz();
`ifdef SEVEN_SEG_DP_EN
    test_dp();
`endif
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
